mem_port_arbiter: RTL

- Shares one unified memory port between the CPU instruction-fetch port and data port.
- Sits between the cpu and a single memory model in the system top and testbench.
- Uses the same level-req / ack handshake on every side.
- Provides fixed or round-robin arbitration, response registering, and a per-transaction timeout that reports a fault.

---
 rtl/mem_port_arbiter_pkg.sv | 45 ++++
 rtl/mem_port_arbiter_timer.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module : mem_port_arbiter_pkg
// Brief  : Shared widths, encodings and grant helper for the memory port arbiter
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int         C_XLEN      = 32;
    localparam logic [2:0] C_FUNCT3_LW = 3'b010;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_INST = 2'd1,
        ARB_DATA = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_t;

    // Only meaningful when at least one request is pending.
    function automatic grant_t pick_grant(input logic   inst_req,
                                          input logic   data_req,
                                          input logic   round_robin,
                                          input grant_t last_grant);
        grant_t g;
        g = GRANT_INST;
        if (inst_req && data_req) begin
            if (round_robin)
                g = (last_grant == GRANT_INST) ? GRANT_DATA : GRANT_INST;
            else
                g = GRANT_DATA;
        end else if (data_req) begin
            g = GRANT_DATA;
        end
        return g;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_timer.sv
// ============================================================================
// Module : mem_port_arbiter_timer
// Brief  : Clearable busy-cycle counter flagging a memory-ack timeout
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            localparam int              C_CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [C_CW-1:0] C_LAST = C_CW'(TIMEOUT_CYCLES - 1);

            logic [C_CW-1:0] r_count;

            // Saturates at the last value so a stalled FSM keeps seeing expiry.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    r_count <= '0;
                else if (i_clear)
                    r_count <= '0;
                else if (i_enable && (r_count != C_LAST))
                    r_count <= r_count + 1'b1;
            end

            assign o_expired = i_enable && (r_count == C_LAST);
        end else begin : g_no_timer
            logic w_unused;
            assign w_unused  = ^{i_clk, i_rst_n, i_clear, i_enable};
            assign o_expired = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Arbitrates CPU fetch and data ports onto one req/ack memory port
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN           = C_XLEN,
    parameter bit ROUND_ROBIN    = 1'b0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_inst_req,
    input  logic [XLEN-1:0] i_inst_addr,
    output logic            o_inst_ack,
    output logic [XLEN-1:0] o_inst_data,
    input  logic            i_data_req,
    input  logic [XLEN-1:0] i_data_addr,
    input  logic [XLEN-1:0] i_data_wdata,
    input  logic [2:0]      i_funct3,
    input  logic            i_readwrite,
    output logic            o_data_ack,
    output logic [XLEN-1:0] o_data_rdata,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [2:0]      o_mem_funct3,
    output logic            o_mem_rw,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_fault
);

    arb_state_t      r_state,        w_state_next;
    grant_t          r_last_grant,   w_last_grant_next;
    grant_t          w_grant;
    logic            r_mem_req,      w_mem_req_next;
    logic [XLEN-1:0] r_mem_addr,     w_mem_addr_next;
    logic [XLEN-1:0] r_mem_wdata,    w_mem_wdata_next;
    logic [2:0]      r_mem_funct3,   w_mem_funct3_next;
    logic            r_mem_rw,       w_mem_rw_next;
    logic            r_inst_ack,     w_inst_ack_next;
    logic [XLEN-1:0] r_inst_data,    w_inst_data_next;
    logic            r_data_ack,     w_data_ack_next;
    logic [XLEN-1:0] r_data_rdata,   w_data_rdata_next;
    logic            r_fault,        w_fault_next;
    logic [XLEN-1:0] w_rsp_data;
    logic            w_busy;
    logic            w_expired;

    assign w_busy = (r_state == ARB_INST) || (r_state == ARB_DATA);

    mem_port_arbiter_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (!w_busy),
        .i_enable  (w_busy),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= GRANT_INST;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_funct3 <= '0;
            r_mem_rw     <= 1'b0;
            r_inst_ack   <= 1'b0;
            r_inst_data  <= '0;
            r_data_ack   <= 1'b0;
            r_data_rdata <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_mem_req    <= w_mem_req_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_mem_funct3 <= w_mem_funct3_next;
            r_mem_rw     <= w_mem_rw_next;
            r_inst_ack   <= w_inst_ack_next;
            r_inst_data  <= w_inst_data_next;
            r_data_ack   <= w_data_ack_next;
            r_data_rdata <= w_data_rdata_next;
            r_fault      <= w_fault_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_grant           = GRANT_INST;
        w_mem_req_next    = r_mem_req;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_mem_funct3_next = r_mem_funct3;
        w_mem_rw_next     = r_mem_rw;
        w_inst_ack_next   = 1'b0;
        w_inst_data_next  = r_inst_data;
        w_data_ack_next   = 1'b0;
        w_data_rdata_next = r_data_rdata;
        w_fault_next      = r_fault;
        w_rsp_data        = '0;

        case (r_state)
            ARB_IDLE: begin
                if (i_inst_req || i_data_req) begin
                    w_grant           = pick_grant(i_inst_req, i_data_req, ROUND_ROBIN, r_last_grant);
                    w_last_grant_next = w_grant;
                    w_mem_req_next    = 1'b1;
                    if (w_grant == GRANT_INST) begin
                        w_state_next      = ARB_INST;
                        w_mem_addr_next   = i_inst_addr;
                        w_mem_wdata_next  = '0;
                        w_mem_funct3_next = C_FUNCT3_LW;
                        w_mem_rw_next     = 1'b0;
                    end else begin
                        w_state_next      = ARB_DATA;
                        w_mem_addr_next   = i_data_addr;
                        w_mem_wdata_next  = i_data_wdata;
                        w_mem_funct3_next = i_funct3;
                        w_mem_rw_next     = i_readwrite;
                    end
                end
            end
            ARB_INST, ARB_DATA: begin
                // A timed-out transaction completes like a normal one, with zero data.
                if (i_mem_ack || w_expired) begin
                    w_mem_req_next = 1'b0;
                    w_state_next   = ARB_RESP;
                    w_rsp_data     = i_mem_ack ? i_mem_rdata : '0;
                    if (!i_mem_ack)
                        w_fault_next = 1'b1;
                    if (r_state == ARB_INST) begin
                        w_inst_ack_next  = 1'b1;
                        w_inst_data_next = w_rsp_data;
                    end else begin
                        w_data_ack_next   = 1'b1;
                        w_data_rdata_next = w_rsp_data;
                    end
                end
            end
            ARB_RESP: begin
                w_state_next = ARB_IDLE;
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_funct3 = r_mem_funct3;
    assign o_mem_rw     = r_mem_rw;
    assign o_inst_ack   = r_inst_ack;
    assign o_inst_data  = r_inst_data;
    assign o_data_ack   = r_data_ack;
    assign o_data_rdata = r_data_rdata;
    assign o_fault      = r_fault;

endmodule

`default_nettype wire
